baud_gen: RTL and testbench

Baud-rate tick generator for the UART transmit path. It divides the system clock down to a single-cycle enable pulse at the serial bit rate. That pulse drives the `tx_en` input of the UART transmitter; the transmitter shifts one bit per pulse. It sits between the clocking block (100 MHz board clock → PLL) and the UART, and is clocked by the PLL output with reset tied to the inverted PLL lock.

---
 rtl/baud_gen_pkg.sv | 23 ++
 rtl/tick_divider.sv | 48 ++++
 rtl/baud_gen.sv | 52 +++++
 tb/tb_baud_gen.sv | 109 ++++++++++
 4 files changed

// File: rtl/baud_gen_pkg.sv
// baud_gen_pkg: shared constants and divisor arithmetic for the UART baud generator.
// The optional oversample divider in baud_gen is enabled by BAUD_GEN_OVERSAMPLE_EN.

package baud_gen_pkg;

    // Board defaults: 100 MHz PLL output, 9600 bit/s, 16x receive oversampling.
    localparam int unsigned DEF_CLK_FREQ_HZ = 100_000_000;
    localparam int unsigned DEF_BAUD_RATE   = 9600;
    localparam int unsigned DEF_OVERSAMPLE  = 16;

    // Divisor rounded to nearest: (clk_hz + rate/2) / rate.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned rate);
        return (clk_hz + rate / 2) / rate;
    endfunction

    // Counter width for a modulo-div counter. Clamped to 1 so an illegal div
    // still elaborates far enough for the divider's own error to be reported.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running modulo-DIV counter producing a registered
// one-cycle tick on every wrap to zero.

module tick_divider
    import baud_gen_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned     CntW   = cnt_width(DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    // A divisor below 2 cannot produce a pulse that is low between ticks.
    generate
        if (DIV < 2) begin : gen_div_check
            $error("tick_divider: DIV must be at least 2");
        end
    endgenerate

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            wrap;
    logic            tick_q;

    // Next count: wrap from DIV-1 back to 0, otherwise increment.
    always_comb begin
        wrap  = (cnt_q == CntMax);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    // Counter and tick registers; the tick is high for the cycle after the wrap edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= wrap;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/baud_gen.sv
// baud_gen: baud-rate tick generator for the UART transmit path.
// Define BAUD_GEN_OVERSAMPLE_EN to add the rx_en oversample tick and its divider.

module baud_gen
    import baud_gen_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int unsigned BAUD_RATE   = DEF_BAUD_RATE,
    parameter int unsigned OVERSAMPLE  = DEF_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
`ifdef BAUD_GEN_OVERSAMPLE_EN
    output logic tx_en,
    output logic rx_en
`else
    output logic tx_en
`endif
);

    localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE);

    // OVERSAMPLE is a divisor term for the oversample rate, so zero is never legal.
    generate
        if (OVERSAMPLE == 0) begin : gen_os_check
            $error("baud_gen: OVERSAMPLE must be nonzero");
        end
    endgenerate

    // Bit-rate divider feeding the transmitter.
    tick_divider #(
        .DIV (DIV)
    ) u_tx_div (
        .clk  (clk),
        .rst  (rst),
        .tick (tx_en)
    );

`ifdef BAUD_GEN_OVERSAMPLE_EN
    localparam int unsigned DIV_OS = calc_div(CLK_FREQ_HZ, BAUD_RATE * OVERSAMPLE);

    // Independent divider so rounding of the oversample rate never disturbs tx_en.
    tick_divider #(
        .DIV (DIV_OS)
    ) u_rx_div (
        .clk  (clk),
        .rst  (rst),
        .tick (rx_en)
    );
`endif

endmodule

// File: tb/tb_baud_gen.sv
// tb_baud_gen: directed check of baud_gen at the default rate (DIV 10417),
// DIV 10 (1000 Hz / 100) and the rounding case DIV 3 (1000 Hz / 300).

module tb_baud_gen;

    // Hand-computed divisors.
    localparam int unsigned DivDef   = 10417; // (100e6 + 4800) / 9600
    localparam int unsigned DivOsDef = 651;   // (100e6 + 76800) / 153600
    localparam int unsigned Div10    = 10;    // (1000 + 50) / 100
    localparam int unsigned Div3     = 3;     // (1000 + 150) / 300 = 3.83 -> 3

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_def, tx_d10, tx_d3;
    logic rx_def, rx_d10, rx_d3;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef BAUD_GEN_OVERSAMPLE_EN
    baud_gen u_def (.clk(clk), .rst(rst), .tx_en(tx_def), .rx_en(rx_def));
    baud_gen #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .OVERSAMPLE(1)) u_d10 (
        .clk(clk), .rst(rst), .tx_en(tx_d10), .rx_en(rx_d10));
    baud_gen #(.CLK_FREQ_HZ(1000), .BAUD_RATE(300), .OVERSAMPLE(1)) u_d3 (
        .clk(clk), .rst(rst), .tx_en(tx_d3), .rx_en(rx_d3));
`else
    baud_gen u_def (.clk(clk), .rst(rst), .tx_en(tx_def));
    baud_gen #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .OVERSAMPLE(1)) u_d10 (
        .clk(clk), .rst(rst), .tx_en(tx_d10));
    baud_gen #(.CLK_FREQ_HZ(1000), .BAUD_RATE(300), .OVERSAMPLE(1)) u_d3 (
        .clk(clk), .rst(rst), .tx_en(tx_d3));
    assign rx_def = 1'b0;
    assign rx_d10 = 1'b0;
    assign rx_d3  = 1'b0;
`endif

    task automatic check_bit(input string tag, input int k, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s edge %0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag, input int k);
        check_bit({tag, "_tx_def"}, k, tx_def, 1'b0);
        check_bit({tag, "_tx_d10"}, k, tx_d10, 1'b0);
        check_bit({tag, "_tx_d3"},  k, tx_d3,  1'b0);
`ifdef BAUD_GEN_OVERSAMPLE_EN
        check_bit({tag, "_rx_def"}, k, rx_def, 1'b0);
        check_bit({tag, "_rx_d10"}, k, rx_d10, 1'b0);
        check_bit({tag, "_rx_d3"},  k, rx_d3,  1'b0);
`endif
    endtask

    // k = rising edges since rst dropped; a tick is visible after edges DIV, 2*DIV, ...
    task automatic check_run(input string tag, input int k);
        check_bit({tag, "_tx_def"}, k, tx_def, (k % DivDef) == 0);
        check_bit({tag, "_tx_d10"}, k, tx_d10, (k % Div10) == 0);
        check_bit({tag, "_tx_d3"},  k, tx_d3,  (k % Div3) == 0);
`ifdef BAUD_GEN_OVERSAMPLE_EN
        check_bit({tag, "_rx_def"}, k, rx_def, (k % DivOsDef) == 0);
        check_bit({tag, "_rx_d10"}, k, rx_d10, (k % Div10) == 0);
        check_bit({tag, "_rx_d3"},  k, rx_d3,  (k % Div3) == 0);
`endif
    endtask

    initial begin
        // Reset held for 1 us from time 0: every output stays low.
        rst = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            check_zero("rst_hold", i);
        end

        // Release; run two full default periods plus 5000 counts, checking every cycle.
        rst = 1'b0;
        for (int k = 1; k <= 2 * DivDef + 5000; k++) begin
            step();
            check_run("run1", k);
        end

        // Default counter now sits at 5000: reset mid-period for 3 cycles.
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_zero("rst_mid", i);
        end

        // Period restarts from 0: next default tick comes DivDef edges after release.
        rst = 1'b0;
        for (int k = 1; k <= DivDef + 30; k++) begin
            step();
            check_run("run2", k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
